apb_slave_regs: RTL and testbench

- APB3 responder that terminates the APB master side of the AXI-Lite to APB bridge.
- Holds a small memory-mapped register file.
- Inserts a parameterised number of wait states.
- Returns PSLVERR for unmapped, unaligned or read-only-write accesses, which exercises the bridge's PREADY, PSLVERR and timeout paths.
- Sits on the APB segment as the bridge's downstream peer and as a reusable bench target.

---
 rtl/apb_slave_regs_pkg.sv | 19 +
 rtl/apb_slv_regfile.sv | 93 +++++++++
 rtl/apb_slave_regs.sv | 160 ++++++++++++++++
 tb/tb_apb_slave_regs.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/apb_slave_regs_pkg.sv
// -----------------------------------------------------------------------------
// apb_slave_regs_pkg
// Shared definitions for the APB register slave: FSM state encodings, APB
// response codes (same encoding as the AXI-Lite side of the bridge) and the
// default APB address width.
// -----------------------------------------------------------------------------
package apb_slave_regs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int APB_ADDR_WIDTH_DEF = 16;

endpackage

// File: rtl/apb_slv_regfile.sv
// -----------------------------------------------------------------------------
// apb_slv_regfile
// Register storage for apb_slave_regs. Registers 0..NUM_REGS-2 are read/write;
// register NUM_REGS-1 is read-only and returns status_i.
// Ports:
//   clk_i, rst_ni      clock, synchronous active-low reset
//   rd_addr_i          byte address being decoded (setup phase PADDR)
//   rd_write_i         access direction for the decode
//   dec_err_o          unaligned, unmapped, or write to the read-only register
//   rd_data_o          read mux output, 0 when dec_err_o is set
//   status_i           value mapped onto the read-only register
//   wr_en_i            commit a write this edge
//   wr_idx_i           register index to write
//   wr_data_i          write data
//   wr_strb_i          byte strobes (all ones when strobes are not in use)
//   ctrl_o             continuous copy of register 0
// -----------------------------------------------------------------------------
import apb_slave_regs_pkg::*;

module apb_slv_regfile #(
    parameter int APB_ADDR_WIDTH = APB_ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_REGS       = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [APB_ADDR_WIDTH-1:0] rd_addr_i,
    input  logic                      rd_write_i,
    output logic                      dec_err_o,
    output logic [DATA_WIDTH-1:0]     rd_data_o,
    input  logic [DATA_WIDTH-1:0]     status_i,
    input  logic                      wr_en_i,
    input  logic [$clog2(NUM_REGS)-1:0] wr_idx_i,
    input  logic [DATA_WIDTH-1:0]     wr_data_i,
    input  logic [DATA_WIDTH/8-1:0]   wr_strb_i,
    output logic [DATA_WIDTH-1:0]     ctrl_o
);

    localparam int IW = APB_ADDR_WIDTH - 2;
    localparam int RW = $clog2(NUM_REGS);
    localparam int NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_q [NUM_REGS-1];
    logic [IW-1:0]         full_idx;
    logic [RW-1:0]         rd_idx;
    logic [DATA_WIDTH-1:0] wr_bits;

    assign full_idx = rd_addr_i[APB_ADDR_WIDTH-1:2];
    assign rd_idx   = full_idx[RW-1:0];

    // Full-width index compare so aliases above NUM_REGS are rejected.
    assign dec_err_o = (rd_addr_i[1:0] != 2'b00)
                     | (full_idx >= IW'(NUM_REGS))
                     | (rd_write_i & (full_idx == IW'(NUM_REGS - 1)));

    always_comb begin
        rd_data_o = '0;
        if (!dec_err_o) begin
            if (rd_idx == RW'(NUM_REGS - 1)) begin
                rd_data_o = status_i;
            end
            for (int unsigned i = 0; i < NUM_REGS - 1; i++) begin
                if (rd_idx == RW'(i)) begin
                    rd_data_o = mem_q[i];
                end
            end
        end
    end

    always_comb begin
        wr_bits = '0;
        for (int unsigned b = 0; b < NB; b++) begin
            wr_bits[b*8 +: 8] = {8{wr_strb_i[b]}};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NUM_REGS - 1; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            for (int unsigned i = 0; i < NUM_REGS - 1; i++) begin
                if (wr_idx_i == RW'(i)) begin
                    mem_q[i] <= (mem_q[i] & ~wr_bits) | (wr_data_i & wr_bits);
                end
            end
        end
    end

    assign ctrl_o = mem_q[0];

endmodule

// File: rtl/apb_slave_regs.sv
// -----------------------------------------------------------------------------
// apb_slave_regs
// APB3 responder with a small word-addressed register file at base 0x0000,
// WAIT_CYCLES wait states per transfer and PSLVERR for unaligned, unmapped or
// read-only-write accesses.
// Optional feature: define APB_SLV_PSTRB_EN to add the APB4 PSTRB input and
// byte-masked writes; without it every write updates the whole word.
// Ports:
//   ACLK, ARESETn            clock, synchronous active-low reset
//   PSEL, PENABLE, PWRITE    APB control
//   PADDR, PWDATA            APB address / write data
//   PRDATA, PREADY, PSLVERR  APB response
//   status_in                value returned by register NUM_REGS-1
//   ctrl_out                 continuous copy of register 0
//   PSTRB                    byte strobes (APB_SLV_PSTRB_EN only)
// UD is kept for parameter-override compatibility; assignments carry no delay.
// -----------------------------------------------------------------------------
import apb_slave_regs_pkg::*;

module apb_slave_regs #(
    parameter int UD             = 1,
    parameter int APB_ADDR_WIDTH = APB_ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_REGS       = 8,
    parameter int WAIT_CYCLES    = 2
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    input  logic                      PWRITE,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0]     PWDATA,
    output logic [DATA_WIDTH-1:0]     PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic [DATA_WIDTH-1:0]     status_in,
    output logic [DATA_WIDTH-1:0]     ctrl_out
`ifdef APB_SLV_PSTRB_EN
    ,
    input  logic [DATA_WIDTH/8-1:0]   PSTRB
`endif
);

    localparam int         RW     = $clog2(NUM_REGS);
    localparam logic [3:0] WAIT_L = 4'(WAIT_CYCLES);

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15 || UD < 0) begin : g_param_check
        $error("apb_slave_regs: WAIT_CYCLES must be 0..15 and UD non-negative");
    end

    apb_state_e            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [RW-1:0]         idx_q, idx_d;
    logic                  write_q, write_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH/8-1:0] strb_q, strb_d;

    logic                  dec_err;
    logic [DATA_WIDTH-1:0] dec_rdata;
    logic                  wr_en;
    logic                  setup_strb_unused;
    logic [DATA_WIDTH/8-1:0] setup_strb;

`ifdef APB_SLV_PSTRB_EN
    assign setup_strb = PSTRB;
`else
    assign setup_strb = '1;
`endif
    assign setup_strb_unused = 1'b0;

    apb_slv_regfile #(
        .APB_ADDR_WIDTH (APB_ADDR_WIDTH),
        .DATA_WIDTH     (DATA_WIDTH),
        .NUM_REGS       (NUM_REGS)
    ) u_regfile (
        .clk_i      (ACLK),
        .rst_ni     (ARESETn),
        .rd_addr_i  (PADDR),
        .rd_write_i (PWRITE),
        .dec_err_o  (dec_err),
        .rd_data_o  (dec_rdata),
        .status_i   (status_in),
        .wr_en_i    (wr_en),
        .wr_idx_i   (idx_q),
        .wr_data_i  (wdata_q),
        .wr_strb_i  (strb_q),
        .ctrl_o     (ctrl_out)
    );

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            write_q <= write_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        write_d = write_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        case (state_q)
            ST_IDLE: begin
                if (PSEL && !PENABLE && !setup_strb_unused) begin
                    idx_d   = PADDR[RW+1:2];
                    write_d = PWRITE;
                    err_d   = dec_err;
                    rdata_d = dec_rdata;
                    wdata_d = PWDATA;
                    strb_d  = setup_strb;
                    cnt_d   = WAIT_L;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // Dropping PSEL mid-transfer abandons it without a write.
                if (!PSEL) begin
                    state_d = ST_IDLE;
                end else if (PENABLE) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        PREADY  = (state_q == ST_ACCESS) && (cnt_q == '0);
        PSLVERR = PREADY & err_q;
        PRDATA  = (PREADY & ~err_q & ~write_q) ? rdata_q : '0;
        wr_en   = PREADY & PSEL & PENABLE & write_q & ~err_q;
    end

endmodule

// File: tb/tb_apb_slave_regs.sv
// -----------------------------------------------------------------------------
// tb_apb_slave_regs
// Two instances share one APB bus: WAIT_CYCLES=2 (cur=0) and WAIT_CYCLES=0
// (cur=1). PSEL is routed to the selected instance and its response is muxed
// back. The driver pushes the expected completion of each transfer into a
// queue; the monitor pops and compares whenever PREADY is seen in an access
// phase, also checking the number of wait cycles.
// -----------------------------------------------------------------------------
module tb_apb_slave_regs;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        err;
        int          waits;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        psel, penable, pwrite, cur;
    logic [15:0] paddr;
    logic [31:0] pwdata, status;
    logic [3:0]  pstrb;

    logic [31:0] prdata2, prdata0, ctrl2, ctrl0;
    logic        pready2, pready0, pslverr2, pslverr0;
    logic        psel2, psel0;
    logic [31:0] prdata, ctrl;
    logic        pready, pslverr;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model[7];
    time         t0;

    always #5 clk = ~clk;

    assign psel2   = psel & ~cur;
    assign psel0   = psel & cur;
    assign prdata  = cur ? prdata0  : prdata2;
    assign pready  = cur ? pready0  : pready2;
    assign pslverr = cur ? pslverr0 : pslverr2;
    assign ctrl    = cur ? ctrl0    : ctrl2;

    apb_slave_regs #(.WAIT_CYCLES(2)) dut_w2 (
        .ACLK(clk), .ARESETn(rst_n), .PSEL(psel2), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata2),
        .PREADY(pready2), .PSLVERR(pslverr2), .status_in(status),
        .ctrl_out(ctrl2)
`ifdef APB_SLV_PSTRB_EN
        , .PSTRB(pstrb)
`endif
    );

    apb_slave_regs #(.WAIT_CYCLES(0)) dut_w0 (
        .ACLK(clk), .ARESETn(rst_n), .PSEL(psel0), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata0),
        .PREADY(pready0), .PSLVERR(pslverr0), .status_in(status),
        .ctrl_out(ctrl0)
`ifdef APB_SLV_PSTRB_EN
        , .PSTRB(pstrb)
`endif
    );

    function automatic void check32(input string name, input logic [31:0] act,
                                     input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endfunction

    // Monitor: count PREADY-low access cycles, compare at completion.
    initial begin
        int   waits;
        exp_t e;
        waits = 0;
        forever begin
            @(negedge clk);
            if (!rst_n || !psel) begin
                waits = 0;
            end else if (penable) begin
                if (!pready) begin
                    waits++;
                end else if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected completion: got PREADY=1, expected none");
                    waits = 0;
                end else begin
                    e = sb.pop_front();
                    check32({e.name, " PRDATA"}, prdata, e.rdata);
                    check32({e.name, " PSLVERR"}, {31'b0, pslverr}, {31'b0, e.err});
                    check32({e.name, " waits"}, 32'(waits), 32'(e.waits));
                    waits = 0;
                end
            end
        end
    end

    // Caller is idle or just past a completion edge; leaves just past one.
    task automatic xfer(input string name, input logic w, input logic [15:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input int exp_waits);
        exp_t e;
        bit   done;
        e.name = name; e.rdata = exp_rd; e.err = exp_err; e.waits = exp_waits;
        sb.push_back(e);
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d; pstrb = s;
        @(posedge clk); #1;
        penable = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (pready) done = 1'b1;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: got no PREADY in 40 cycles, expected PREADY", name);
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = 4'hF; cur = 1'b0;
        status = 32'h12345678;
        for (int i = 0; i < 7; i++) model[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        check32("rst PREADY w2",  {31'b0, pready2},  0);
        check32("rst PSLVERR w2", {31'b0, pslverr2}, 0);
        check32("rst PRDATA w2",  prdata2, 0);
        check32("rst ctrl_out w2", ctrl2, 0);
        check32("rst PREADY w0",  {31'b0, pready0},  0);
        check32("rst ctrl_out w0", ctrl0, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic write/read with two wait states.
        xfer("wr 0x04", 1, 16'h0004, 32'hDEADBEEF, 4'hF, 0, 0, 2);
        model[1] = 32'hDEADBEEF;
        xfer("rd 0x04", 0, 16'h0004, 0, 4'hF, 32'hDEADBEEF, 0, 2);

        // Read-only status register.
        xfer("rd 0x1C", 0, 16'h001C, 0, 4'hF, 32'h12345678, 0, 2);
        xfer("wr 0x1C ro", 1, 16'h001C, 32'hFFFFFFFF, 4'hF, 0, 1, 2);
        xfer("rd 0x1C after wr", 0, 16'h001C, 0, 4'hF, 32'h12345678, 0, 2);
        status = 32'hCAFEF00D;
        xfer("rd 0x1C new status", 0, 16'h001C, 0, 4'hF, 32'hCAFEF00D, 0, 2);

        // Unmapped and unaligned accesses.
        xfer("rd 0x20", 0, 16'h0020, 0, 4'hF, 0, 1, 2);
        xfer("rd 0x06", 0, 16'h0006, 0, 4'hF, 0, 1, 2);
        xfer("wr 0x20", 1, 16'h0020, 32'h5, 4'hF, 0, 1, 2);
        xfer("wr 0x06", 1, 16'h0006, 32'h5, 4'hF, 0, 1, 2);
        for (int i = 0; i < 7; i++) begin
            xfer($sformatf("rd reg%0d after err", i), 0, 16'(i * 4), 0, 4'hF,
                 model[i], 0, 2);
        end

        // Master abort in the first wait cycle of a write to reg2.
        xfer("wr 0x08", 1, 16'h0008, 32'h22222222, 4'hF, 0, 0, 2);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0008; pwdata = 32'h99;
        @(posedge clk); #1;
        psel = 1'b0;
        @(negedge clk);
        check32("abort PREADY", {31'b0, pready}, 0);
        @(posedge clk); #1;
        xfer("rd 0x08 after abort", 0, 16'h0008, 0, 4'hF, 32'h22222222, 0, 2);

        xfer("wr 0x00 w2", 1, 16'h0000, 32'h0F0F0F0F, 4'hF, 0, 0, 2);
        check32("ctrl_out w2", ctrl2, 32'h0F0F0F0F);

        // Zero wait states, back to back.
        cur = 1'b1;
        t0 = $time;
        xfer("w0 wr 0x00", 1, 16'h0000, 32'h000000A5, 4'hF, 0, 0, 0);
        check32("ctrl_out after completion", ctrl0, 32'h000000A5);
        xfer("w0 wr 0x04", 1, 16'h0004, 32'h00001111, 4'hF, 0, 0, 0);
        xfer("w0 wr 0x08", 1, 16'h0008, 32'h00002222, 4'hF, 0, 0, 0);
        xfer("w0 wr 0x0C", 1, 16'h000C, 32'h00003333, 4'hF, 0, 0, 0);
        check32("w0 back-to-back ns", 32'($time - t0), 80);
        xfer("w0 rd 0x0C", 0, 16'h000C, 0, 4'hF, 32'h00003333, 0, 0);
        xfer("w0 rd 0x04", 0, 16'h0004, 0, 4'hF, 32'h00001111, 0, 0);
        xfer("w0 wr 0x1C ro", 1, 16'h001C, 32'h1, 4'hF, 0, 1, 0);

        // Reset in the last wait cycle of a write to reg0.
        cur = 1'b0;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0000; pwdata = 32'h77;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check32("reset mid PREADY", {31'b0, pready2}, 0);
        check32("reset mid PSLVERR", {31'b0, pslverr2}, 0);
        check32("reset mid ctrl_out", ctrl2, 0);
        psel = 1'b0; penable = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 7; i++) begin
            xfer($sformatf("rd reg%0d after reset", i), 0, 16'(i * 4), 0, 4'hF,
                 0, 0, 2);
        end

`ifdef APB_SLV_PSTRB_EN
        xfer("strb wr full", 1, 16'h0004, 32'h11223344, 4'hF, 0, 0, 2);
        xfer("strb wr 0010", 1, 16'h0004, 32'hAABBCCDD, 4'b0010, 0, 0, 2);
        xfer("strb rd", 0, 16'h0004, 0, 4'b0000, 32'h1122CC44, 0, 2);
        xfer("strb wr 0000", 1, 16'h0004, 32'hFFFFFFFF, 4'b0000, 0, 0, 2);
        xfer("strb rd after 0", 0, 16'h0004, 0, 4'hF, 32'h1122CC44, 0, 2);
`endif

        repeat (3) @(posedge clk);
        #1;
        check32("scoreboard drained", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
